cnt_seq: RTL and testbench

- Iterative count unit for the bit-manipulation datapath; implements clz, ctz and cpop (plus W-word variants) over multiple cycles.
- Scans the operand one CHUNK-bit slice per cycle with a single CHUNK-wide leading-zero/popcount slice, instead of one full-WIDTH combinational count.
- Sits beside the BMU as a multi-cycle functional unit; the issue logic talks to it through a Start/Busy/Done handshake.

---
 rtl/cnt_seq.sv | 188 ++++++++++++++++++
 tb/tb_cnt_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq.sv
// cnt_seq: iterative clz / ctz / cpop unit (plus 32-bit "W" variants).
// The operand is scanned CHUNK bits per cycle, most significant chunk first,
// through one CHUNK-wide leading-zero / popcount slice. An accumulator sums
// the per-chunk counts.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   Start  - request; sampled only while idle
//   Flush  - abort the current operation (wins over Start)
//   CntOp  - 00 clz, 01 ctz, 10 cpop, 11 reserved (runs as clz)
//   Word   - operate on A[WIDTH/2-1:0] only
//   A      - operand, sampled with Start
//   Busy   - high while chunks are being scanned
//   Done   - one-cycle pulse; Result valid
//   Result - count, held until the next Done
`timescale 1ns/1ps
module cnt_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic                     Flush,
    input  logic [1:0]               CntOp,
    input  logic                     Word,
    input  logic [WIDTH-1:0]         A,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(WIDTH):0]   Result
);

    localparam int RW  = $clog2(WIDTH) + 1;
    localparam int CW  = $clog2(CHUNK) + 1;
    localparam int NCH = WIDTH / CHUNK;
    localparam int NW  = $clog2(NCH);
    localparam logic [NW-1:0] LAST_FULL = NW'(NCH - 1);
    localparam logic [NW-1:0] LAST_WORD = NW'(NCH / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[WIDTH-1-i] = v[i];
        end
        return r;
    endfunction

    // Leading zeros of one chunk; CHUNK when the chunk is all zero.
    function automatic logic [CW-1:0] lzc_chunk(input logic [CHUNK-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            n     = n + CW'(!found && !v[i]);
            found = found | v[i];
        end
        return n;
    endfunction

    function automatic logic [CW-1:0] pop_chunk(input logic [CHUNK-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    state_t            state_r, state_n;
    logic [WIDTH-1:0]  scan_r, scan_n;
    logic [1:0]        op_r, op_n;
    logic              word_r, word_n;
    logic [RW-1:0]     acc_r, acc_n;
    logic [NW-1:0]     cnt_r, cnt_n;
    logic [RW-1:0]     result_r, result_n;
    logic              done_r, done_n;

    logic [WIDTH-1:0]  load_s;
    logic [CHUNK-1:0]  chunk_s;
    logic              is_cpop_s;
    logic [NW-1:0]     last_idx_s;
    logic              last_s;
    logic [CW-1:0]     add_s;
    logic [RW-1:0]     acc_sum_s;

    // The field is left-aligned in the scan register so the top chunk is
    // always the next one. For ctz the upper half of the full reversal is
    // exactly the reversed low half, so Word needs no special case there.
    always_comb begin
        load_s = A;
        case (CntOp)
            2'b01:   load_s = bit_reverse(A);
            default: begin
                if (Word) begin
                    load_s = {A[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                end else begin
                    load_s = A;
                end
            end
        endcase
    end

    assign chunk_s    = scan_r[WIDTH-1 -: CHUNK];
    assign is_cpop_s  = (op_r == 2'b10);
    assign last_idx_s = word_r ? LAST_WORD : LAST_FULL;
    // clz/ctz stop at the first nonzero chunk; cpop always visits every chunk.
    assign last_s     = (cnt_r == last_idx_s) || (!is_cpop_s && (chunk_s != '0));
    assign add_s      = is_cpop_s ? pop_chunk(chunk_s) : lzc_chunk(chunk_s);
    assign acc_sum_s  = acc_r + RW'(add_s);

    // Next-state and datapath update for the IDLE / BUSY / DONE sequence.
    always_comb begin
        state_n  = state_r;
        scan_n   = scan_r;
        op_n     = op_r;
        word_n   = word_r;
        acc_n    = acc_r;
        cnt_n    = cnt_r;
        result_n = result_r;
        done_n   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (Start && !Flush) begin
                    state_n = S_BUSY;
                    scan_n  = load_s;
                    op_n    = CntOp;
                    word_n  = Word;
                    acc_n   = '0;
                    cnt_n   = '0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_BUSY: begin
                if (Flush) begin
                    state_n = S_IDLE;
                end else if (last_s) begin
                    state_n  = S_DONE;
                    result_n = acc_sum_s;
                    done_n   = 1'b1;
                end else begin
                    acc_n  = acc_sum_s;
                    cnt_n  = cnt_r + NW'(1);
                    scan_n = scan_r << CHUNK;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            scan_r   <= '0;
            op_r     <= 2'b00;
            word_r   <= 1'b0;
            acc_r    <= '0;
            cnt_r    <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            scan_r   <= scan_n;
            op_r     <= op_n;
            word_r   <= word_n;
            acc_r    <= acc_n;
            cnt_r    <= cnt_n;
            result_r <= result_n;
            done_r   <= done_n;
        end
    end

    assign Busy   = (state_r == S_BUSY);
    assign Done   = done_r;
    assign Result = result_r;

endmodule

// File: tb/tb_cnt_seq.sv
// Self-checking bench for cnt_seq (WIDTH=64, CHUNK=16). A cycle-level
// timeline model predicts Busy/Done/Result from plain counting of
// leading/trailing zeros and ones; directed vectors carry hand-computed
// results and busy-cycle counts.
`timescale 1ns/1ps
module tb_cnt_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [1:0]  CntOp = 2'b00;
    logic        Word = 1'b0;
    logic [63:0] A = 64'h0;
    logic        Busy;
    logic        Done;
    logic [6:0]  Result;

    cnt_seq #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Flush(Flush),
        .CntOp(CntOp), .Word(Word), .A(A),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_busy_left = 0;
    bit m_done      = 1'b0;
    int m_result    = 0;
    int m_pend      = 0;
    bit started     = 1'b0;

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Spec-level result and number of busy cycles for one operation.
    function automatic void model_op(input logic [1:0] op, input logic word,
                                     input logic [63:0] a, output int res, output int k);
        int fw, n, i;
        fw = word ? 32 : 64;
        n  = fw / 16;
        res = 0;
        if (op == 2'b10) begin
            for (i = 0; i < fw; i++) res += int'(a[i]);
            k = n;
        end else begin
            if (op == 2'b01) begin
                i = 0;
                while (i < fw && a[i] == 1'b0) i++;
                res = i;
            end else begin
                i = fw - 1;
                while (i >= 0 && a[i] == 1'b0) i--;
                res = fw - 1 - i;
            end
            k = (res == fw) ? n : (res / 16 + 1);
        end
    endfunction

    // Timeline model, advanced on each active edge from the sampled inputs.
    always @(posedge clk) begin : model
        int r, k;
        if (reset) begin
            m_busy_left = 0;
            m_done      = 1'b0;
            m_result    = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy_left > 0) begin
            if (Flush) begin
                m_busy_left = 0;
            end else begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_done   = 1'b1;
                    m_result = m_pend;
                end
            end
        end else if (Start && !Flush) begin
            model_op(CntOp, Word, A, r, k);
            m_pend      = r;
            m_busy_left = k;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("busy", longint'(Busy), longint'(m_busy_left > 0));
            check("done", longint'(Done), longint'(m_done));
            check("result", longint'(Result), longint'(m_result));
        end
    end

    task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a);
        @(posedge clk);
        #1;
        Start = 1'b1;
        CntOp = op;
        Word  = word;
        A     = a;
    endtask

    // Follows the load edge; scrambles the operand to show it is not resampled.
    task automatic finish(input int exp_res, input int exp_k, input bit keep_start,
                          input string name);
        int  got_k;
        bit  seen;
        @(posedge clk);
        #1;
        if (!keep_start) Start = 1'b0;
        A     = ~A;
        CntOp = CntOp ^ 2'b01;
        Word  = ~Word;
        got_k = 0;
        seen  = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (Done) seen = 1'b1;
            else if (Busy) got_k++;
        end
        Start = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no Done expected Done within 20 cycles", name);
        end else begin
            check({name, "_busy_cycles"}, got_k, exp_k);
            check({name, "_result"}, longint'(Result), exp_res);
            check({name, "_model"}, m_result, exp_res);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                          input int exp_res, input int exp_k, input string name);
        issue(op, word, a);
        finish(exp_res, exp_k, 1'b0, name);
    endtask

    initial begin
        @(posedge clk);
        #1;
        started = 1'b1;
        check("rst_busy", longint'(Busy), 0);
        check("rst_done", longint'(Done), 0);
        check("rst_result", longint'(Result), 0);
        reset = 1'b0;

        run_op(2'b00, 1'b0, 64'h0000_0000_0001_0000, 47, 3, "clz_bit16");
        run_op(2'b00, 1'b0, 64'h0,                   64, 4, "clz_zero");
        run_op(2'b01, 1'b0, 64'h8000_0000_0000_0000, 63, 4, "ctz_msb");
        run_op(2'b01, 1'b0, 64'h1,                    0, 1, "ctz_one");
        run_op(2'b10, 1'b0, 64'hFFFF_0000_0000_00FF, 24, 4, "cpop_mix");
        run_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 4, "cpop_ones");
        run_op(2'b11, 1'b0, 64'h0000_0000_0001_0000, 47, 3, "rsvd_as_clz");
        run_op(2'b00, 1'b1, 64'hFFFF_FFFF_0000_8000, 16, 2, "clzw");
        run_op(2'b01, 1'b1, 64'h0000_0001_0000_0000, 32, 2, "ctzw");
        run_op(2'b10, 1'b1, 64'hFFFF_FFFF_0000_0003,  2, 2, "cpopw");

        // Start held high with other operands while busy: ignored.
        issue(2'b00, 1'b0, 64'h0000_0000_0001_0000);
        finish(47, 3, 1'b1, "start_in_busy");

        // Flush in the second busy cycle of clz A=0.
        issue(2'b00, 1'b0, 64'h0);
        @(posedge clk);
        #1;
        Start = 1'b0;
        @(posedge clk);
        #1;
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        check("flush_busy", longint'(Busy), 0);
        check("flush_done", longint'(Done), 0);
        check("flush_result", longint'(Result), 47);
        repeat (6) @(posedge clk);

        // Flush and Start together while idle: nothing loads.
        issue(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        Flush = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Flush = 1'b0;
        check("flush_start_busy", longint'(Busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_start_result", longint'(Result), 47);

        // Reset in the middle of an operation, then Start right after it.
        issue(2'b00, 1'b0, 64'h0);
        @(posedge clk);
        #1;
        Start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", longint'(Busy), 0);
        check("midrst_done", longint'(Done), 0);
        check("midrst_result", longint'(Result), 0);
        reset = 1'b0;
        Start = 1'b1;
        CntOp = 2'b10;
        Word  = 1'b0;
        A     = 64'hFFFF_0000_0000_00FF;
        finish(24, 4, 1'b0, "post_rst");

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
